// File: rtl/axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter
//
// Shares one AXI4-Lite-style read master (AR + R channels) between two
// requesters: port 0 is the IFU instruction fetch, port 1 is the LSU load.
// Only one transaction is in flight at a time. When both ports request in the
// same IDLE cycle, the port that was not granted last time wins (round robin).
// A saturating counter records how many read beats came back with a non-OKAY
// response, for debug visibility.
//
// Ports
//   clk, rst_n        clock (rising edge) and synchronous active-low reset
//   s0_* / s1_*       requester ports (IFU / LSU):
//                       arvalid/arready/araddr   read address handshake
//                       rvalid/rready/rdata/rresp read data handshake
//   m_*               single downstream read master (AR + R channels)
//   grant_o           one-hot owner of the current transaction, 2'b00 in IDLE
//   err_cnt_o         saturating count of beats with rresp != OKAY
//
// Transaction flow: IDLE (arbitrate, accept address) -> ADDR (present address
// downstream until accepted) -> DATA (pass the read beat to the owner).
// -----------------------------------------------------------------------------
module axi_rd_arbiter #(
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 64,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,

   input  logic                 s0_arvalid,
   output logic                 s0_arready,
   input  logic [ADDR_W-1:0]    s0_araddr,
   output logic                 s0_rvalid,
   input  logic                 s0_rready,
   output logic [DATA_W-1:0]    s0_rdata,
   output logic [1:0]           s0_rresp,

   input  logic                 s1_arvalid,
   output logic                 s1_arready,
   input  logic [ADDR_W-1:0]    s1_araddr,
   output logic                 s1_rvalid,
   input  logic                 s1_rready,
   output logic [DATA_W-1:0]    s1_rdata,
   output logic [1:0]           s1_rresp,

   output logic                 m_arvalid,
   input  logic                 m_arready,
   output logic [ADDR_W-1:0]    m_araddr,
   input  logic                 m_rvalid,
   output logic                 m_rready,
   input  logic [DATA_W-1:0]    m_rdata,
   input  logic [1:0]           m_rresp,

   output logic [1:0]           grant_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ADDR = 2'b01,
      ST_DATA = 2'b10
   } state_t;

   state_t                 state_r;
   state_t                 state_nxt_s;
   logic                   owner_r;       // 0 = IFU (s0), 1 = LSU (s1)
   logic                   last_grant_r;  // owner of the last completed read
   logic [ADDR_W-1:0]      addr_r;
   logic [ERR_CNT_W-1:0]   err_cnt_r;

   logic                   req_any_s;
   logic                   win_s;
   logic                   rready_own_s;
   logic                   r_hs_s;
   logic                   ar_accept_s;

   // Increment that sticks at the all-ones value instead of wrapping.
   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] val);
      logic [ERR_CNT_W-1:0] res;
      if (&val) begin
         res = val;
      end else begin
         res = val + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end
      return res;
   endfunction

   // Arbitration: a lone requester wins; on a tie the port not granted last time wins.
   always_comb begin
      req_any_s = s0_arvalid | s1_arvalid;
      if (s0_arvalid && s1_arvalid) begin
         win_s = ~last_grant_r;
      end else if (s1_arvalid) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
   end

   // Handshake qualifiers derived from the current state and the owner's ready.
   always_comb begin
      rready_own_s = owner_r ? s1_rready : s0_rready;
      ar_accept_s  = (state_r == ST_IDLE) && req_any_s;
      r_hs_s       = (state_r == ST_DATA) && m_rvalid && rready_own_s;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; IDLE is the only point where a new owner is chosen.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (req_any_s) begin
               state_nxt_s = ST_ADDR;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ADDR: begin
            if (m_arready) begin
               state_nxt_s = ST_DATA;
            end else begin
               state_nxt_s = ST_ADDR;
            end
         end
         ST_DATA: begin
            if (r_hs_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Capture the winner's address and identity when its request is accepted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_r  <= {ADDR_W{1'b0}};
         owner_r <= 1'b0;
      end else if (ar_accept_s) begin
         addr_r  <= win_s ? s1_araddr : s0_araddr;
         owner_r <= win_s;
      end else begin
         addr_r  <= addr_r;
         owner_r <= owner_r;
      end
   end

   // Round-robin history and error counter advance only on a completed beat.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant_r <= 1'b1;
         err_cnt_r    <= {ERR_CNT_W{1'b0}};
      end else if (r_hs_s) begin
         last_grant_r <= owner_r;
         if (m_rresp != 2'b00) begin
            err_cnt_r <= sat_inc(err_cnt_r);
         end else begin
            err_cnt_r <= err_cnt_r;
         end
      end else begin
         last_grant_r <= last_grant_r;
         err_cnt_r    <= err_cnt_r;
      end
   end

   // Output decode. Address acceptance in IDLE is held off while reset is
   // asserted so no requester believes its address was taken during reset.
   always_comb begin
      m_arvalid  = 1'b0;
      m_araddr   = {ADDR_W{1'b0}};
      m_rready   = 1'b0;
      s0_arready = 1'b0;
      s1_arready = 1'b0;
      s0_rvalid  = 1'b0;
      s1_rvalid  = 1'b0;
      s0_rdata   = {DATA_W{1'b0}};
      s1_rdata   = {DATA_W{1'b0}};
      s0_rresp   = 2'b00;
      s1_rresp   = 2'b00;
      grant_o    = 2'b00;
      case (state_r)
         ST_IDLE: begin
            if (rst_n && req_any_s) begin
               if (win_s) begin
                  s1_arready = 1'b1;
               end else begin
                  s0_arready = 1'b1;
               end
            end else begin
               s0_arready = 1'b0;
               s1_arready = 1'b0;
            end
         end
         ST_ADDR: begin
            m_arvalid = 1'b1;
            m_araddr  = addr_r;
            grant_o   = owner_r ? 2'b10 : 2'b01;
         end
         ST_DATA: begin
            grant_o  = owner_r ? 2'b10 : 2'b01;
            m_rready = rready_own_s;
            if (owner_r) begin
               s1_rvalid = m_rvalid;
               s1_rdata  = m_rdata;
               s1_rresp  = m_rresp;
            end else begin
               s0_rvalid = m_rvalid;
               s0_rdata  = m_rdata;
               s0_rresp  = m_rresp;
            end
         end
         default: begin
            grant_o = 2'b00;
         end
      endcase
   end

   assign err_cnt_o = err_cnt_r;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;
   localparam int AW = 64;
   localparam int DW = 64;
   localparam int EW = 8;

   logic          clk;
   logic          rst_n;
   logic          s0_arvalid, s0_arready, s0_rvalid, s0_rready;
   logic [AW-1:0] s0_araddr;
   logic [DW-1:0] s0_rdata;
   logic [1:0]    s0_rresp;
   logic          s1_arvalid, s1_arready, s1_rvalid, s1_rready;
   logic [AW-1:0] s1_araddr;
   logic [DW-1:0] s1_rdata;
   logic [1:0]    s1_rresp;
   logic          m_arvalid, m_arready, m_rvalid, m_rready;
   logic [AW-1:0] m_araddr;
   logic [DW-1:0] m_rdata;
   logic [1:0]    m_rresp;
   logic [1:0]    grant_o;
   logic [EW-1:0] err_cnt_o;

   int checks   = 0;
   int failures = 0;

   logic [66:0] exp_r[$];   // {port, resp, data}
   logic [63:0] exp_ar[$];

   axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ERR_CNT_W(EW)) dut (
      .clk(clk), .rst_n(rst_n),
      .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr),
      .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
      .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr),
      .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
      .grant_o(grant_o), .err_cnt_o(err_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic pop_r(input logic p, input logic [63:0] data, input logic [1:0] resp);
      logic [66:0] e;
      if (exp_r.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL r_unexpected: got beat on port %0d data %0h expected none", p, data);
      end else begin
         e = exp_r.pop_front();
         check("r_port", {63'd0, p}, {63'd0, e[66]});
         check("r_data", data, e[63:0]);
         check("r_resp", {62'd0, resp}, {62'd0, e[65:64]});
      end
   endtask

   // Monitor: every completed R beat and AR handshake is checked against the queues.
   always @(negedge clk) begin
      if (s0_rvalid && s1_rvalid) begin
         checks++;
         failures++;
         $display("FAIL both_rvalid: got both ports valid expected at most one");
      end
      if (s0_rvalid && s0_rready) pop_r(1'b0, s0_rdata, s0_rresp);
      if (s1_rvalid && s1_rready) pop_r(1'b1, s1_rdata, s1_rresp);
      if (m_arvalid && m_arready) begin
         if (exp_ar.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL ar_unexpected: got addr %0h expected none", m_araddr);
         end else begin
            check("ar_addr", m_araddr, exp_ar.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int p, input logic v, input logic [63:0] a);
      if (p == 0) begin s0_arvalid = v; s0_araddr = a; end
      else begin s1_arvalid = v; s1_araddr = a; end
   endtask

   task automatic set_rready(input int p, input logic v);
      if (p == 0) s0_rready = v; else s1_rready = v;
   endtask

   function automatic logic arready_of(input int p);
      return (p == 0) ? s0_arready : s1_arready;
   endfunction
   function automatic logic rvalid_of(input int p);
      return (p == 0) ? s0_rvalid : s1_rvalid;
   endfunction
   function automatic logic [63:0] rdata_of(input int p);
      return (p == 0) ? s0_rdata : s1_rdata;
   endfunction
   function automatic logic [1:0] rresp_of(input int p);
      return (p == 0) ? s0_rresp : s1_rresp;
   endfunction

   task automatic do_reset;
      rst_n = 1'b0;
      s0_arvalid = 1'b0; s0_araddr = '0; s0_rready = 1'b0;
      s1_arvalid = 1'b0; s1_araddr = '0; s1_rready = 1'b0;
      m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
      tick;
      tick;
      rst_n = 1'b1;
   endtask

   // One full transaction for port p, whose arvalid/araddr the caller already drives
   // and which is expected to win arbitration in the current IDLE cycle.
   task automatic serve(input int p, input logic [63:0] addr, input logic [63:0] data,
                        input logic [1:0] resp, input int ar_wait, input int r_stall);
      logic [1:0] g;
      logic       pb;
      g  = (p == 0) ? 2'b01 : 2'b10;
      pb = (p == 1);
      #1;
      check("arready_win", {63'd0, arready_of(p)}, 64'd1);
      check("arready_lose", {63'd0, arready_of(1 - p)}, 64'd0);
      exp_ar.push_back(addr);
      exp_r.push_back({pb, resp, data});
      tick;
      set_req(p, 1'b0, ~addr);
      m_arready = (ar_wait == 0);
      if (ar_wait > 0) begin
         m_rvalid = 1'b1;
         m_rdata  = 64'hDEAD_BEEF;
         set_rready(p, 1'b1);
      end
      #1;
      check("addr_arvalid", {63'd0, m_arvalid}, 64'd1);
      check("addr_araddr", m_araddr, addr);
      check("addr_grant", {62'd0, grant_o}, {62'd0, g});
      check("addr_other_arready", {63'd0, arready_of(1 - p)}, 64'd0);
      for (int i = 1; i < ar_wait; i++) begin
         tick;
         #1;
         check("wait_arvalid", {63'd0, m_arvalid}, 64'd1);
         check("wait_araddr", m_araddr, addr);
         check("wait_other_arready", {63'd0, arready_of(1 - p)}, 64'd0);
         check("wait_m_rready", {63'd0, m_rready}, 64'd0);
         check("wait_stray_rvalid", {63'd0, rvalid_of(p)}, 64'd0);
      end
      m_arready = 1'b1;
      m_rvalid  = 1'b0;
      set_rready(p, 1'b0);
      tick;
      m_arready = 1'b0;
      m_rvalid  = 1'b1;
      m_rdata   = data;
      m_rresp   = resp;
      set_rready(p, r_stall == 0);
      #1;
      check("data_grant", {62'd0, grant_o}, {62'd0, g});
      check("data_rvalid", {63'd0, rvalid_of(p)}, 64'd1);
      check("data_rdata", rdata_of(p), data);
      check("data_rresp", {62'd0, rresp_of(p)}, {62'd0, resp});
      check("data_other_rvalid", {63'd0, rvalid_of(1 - p)}, 64'd0);
      check("data_other_rdata", rdata_of(1 - p), 64'd0);
      check("data_arvalid", {63'd0, m_arvalid}, 64'd0);
      check("data_other_arready", {63'd0, arready_of(1 - p)}, 64'd0);
      for (int i = 1; i < r_stall; i++) begin
         tick;
         #1;
         check("stall_m_rready", {63'd0, m_rready}, 64'd0);
         check("stall_rvalid", {63'd0, rvalid_of(p)}, 64'd1);
         check("stall_rdata", rdata_of(p), data);
         check("stall_grant", {62'd0, grant_o}, {62'd0, g});
      end
      if (r_stall > 0) begin
         set_rready(p, 1'b1);
      end
      #1;
      check("data_m_rready", {63'd0, m_rready}, 64'd1);
      tick;
      m_rvalid = 1'b0;
      m_rdata  = '0;
      m_rresp  = 2'b00;
      set_rready(p, 1'b0);
      #1;
      check("idle_grant", {62'd0, grant_o}, 64'd0);
      check("idle_rvalid", {63'd0, rvalid_of(p)}, 64'd0);
   endtask

   initial begin
      logic [7:0] exp_err;
      int         q;
      do_reset;
      rst_n = 1'b0;
      tick;
      check("rst_arvalid", {63'd0, m_arvalid}, 64'd0);
      check("rst_rready", {63'd0, m_rready}, 64'd0);
      check("rst_grant", {62'd0, grant_o}, 64'd0);
      check("rst_err", {56'd0, err_cnt_o}, 64'd0);
      check("rst_rvalid", {62'd0, s1_rvalid, s0_rvalid}, 64'd0);
      check("rst_arready", {62'd0, s1_arready, s0_arready}, 64'd0);
      rst_n = 1'b1;
      tick;

      // 1: IFU alone
      set_req(0, 1'b1, 64'h8000_0000);
      serve(0, 64'h8000_0000, 64'h1234, 2'b00, 0, 0);

      // 2: simultaneous requests after reset alternate IFU, LSU, IFU
      do_reset;
      set_req(0, 1'b1, 64'h1000);
      set_req(1, 1'b1, 64'h2000);
      serve(0, 64'h1000, 64'hA0A0, 2'b00, 0, 0);
      serve(1, 64'h2000, 64'hB1B1, 2'b00, 0, 0);
      set_req(0, 1'b1, 64'h1008);
      set_req(1, 1'b1, 64'h2008);
      serve(0, 64'h1008, 64'hC2C2, 2'b00, 0, 0);
      serve(1, 64'h2008, 64'hD3D3, 2'b00, 0, 0);

      // 3: slow address acceptance with the other port waiting
      set_req(0, 1'b1, 64'h3000);
      set_req(1, 1'b1, 64'h4000);
      serve(0, 64'h3000, 64'h5555, 2'b00, 5, 0);
      serve(1, 64'h4000, 64'h6666, 2'b00, 0, 0);

      // 6: LSU back-pressures the beat for 4 cycles
      set_req(1, 1'b1, 64'h5000);
      serve(1, 64'h5000, 64'h7777, 2'b01, 0, 4);

      // 4: error responses and counter saturation
      do_reset;
      check("err_before", {56'd0, err_cnt_o}, 64'd0);
      set_req(1, 1'b1, 64'h6000);
      serve(1, 64'h6000, 64'h8888, 2'b10, 0, 0);
      check("err_one", {56'd0, err_cnt_o}, 64'd1);
      for (int n = 2; n <= 300; n++) begin
         q = n % 2;
         set_req(q, 1'b1, 64'h7000 + 64'(n));
         serve(q, 64'h7000 + 64'(n), 64'(n), (q == 0) ? 2'b11 : 2'b10, 0, 0);
         exp_err = (n > 255) ? 8'd255 : 8'(n);
         if (n < 4 || n > 252) check("err_count", {56'd0, err_cnt_o}, {56'd0, exp_err});
      end

      // 5: reset while a beat is pending in DATA
      set_req(1, 1'b1, 64'h9000);
      #1;
      exp_ar.push_back(64'h9000);
      tick;
      set_req(1, 1'b0, 64'h0);
      m_arready = 1'b1;
      tick;
      m_arready = 1'b0;
      m_rvalid  = 1'b1;
      m_rdata   = 64'hBAD;
      m_rresp   = 2'b10;
      #1;
      check("r5_data_rvalid", {63'd0, s1_rvalid}, 64'd1);
      check("r5_data_grant", {62'd0, grant_o}, 64'd2);
      rst_n = 1'b0;
      tick;
      check("r5_grant", {62'd0, grant_o}, 64'd0);
      check("r5_rready", {63'd0, m_rready}, 64'd0);
      check("r5_err", {56'd0, err_cnt_o}, 64'd0);
      check("r5_rvalid", {63'd0, s1_rvalid}, 64'd0);
      check("r5_arvalid", {63'd0, m_arvalid}, 64'd0);
      s1_rready = 1'b1;
      #1;
      check("r5_stray_rvalid", {63'd0, s1_rvalid}, 64'd0);
      check("r5_stray_rready", {63'd0, m_rready}, 64'd0);
      rst_n = 1'b1;
      tick;
      check("r5_idle_rvalid", {62'd0, s1_rvalid, s0_rvalid}, 64'd0);
      check("r5_idle_rready", {63'd0, m_rready}, 64'd0);
      check("r5_idle_grant", {62'd0, grant_o}, 64'd0);
      m_rvalid  = 1'b0;
      s1_rready = 1'b0;
      tick;

      check("exp_r_empty", 64'(exp_r.size()), 64'd0);
      check("exp_ar_empty", 64'(exp_ar.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
